// File: rtl/ddr_burst_pkg.sv
// Shared defaults and FSM encoding for the DDR burst responder slice.
package ddr_burst_pkg;

  localparam int DEF_DDR_DATA_WIDTH = 128;
  localparam int DEF_DDR_ADDR_WIDTH = 28;
  localparam int DEF_MEM_ADDR_WIDTH = 16;
  localparam int DEF_ADDR_STEP      = 8;
  localparam int BURST_LEN_WIDTH    = 10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    READ       = 3'd2,
    READ_DRAIN = 3'd3,
    FINISH     = 3'd4,
    RELEASE    = 3'd5
  } burst_state_t;

endpackage

// File: rtl/ddr_burst_ram.sv
// Simple dual-port backing RAM: one write port, one read port with a registered read.
module ddr_burst_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  mem_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_array [0:(1<<ADDR_WIDTH)-1];

  // No reset here: contents must survive a burst abort.
  always_ff @(posedge mem_clk) begin
    if (wr_en) mem_array[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_array[rd_addr];
  end

endmodule

// File: rtl/ddr_burst_responder.sv
// Memory-backed responder for the DDR burst read/write handshake.
module ddr_burst_responder
  import ddr_burst_pkg::*;
#(
  parameter int DDR_DATA_WIDTH = DEF_DDR_DATA_WIDTH,
  parameter int DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int ADDR_STEP      = DEF_ADDR_STEP
) (
  input  logic                      mem_clk,
  input  logic                      rst,
  input  logic                      rd_burst_req,
  input  logic [9:0]                rd_burst_len,
  input  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  input  logic                      wr_burst_req,
  input  logic [9:0]                wr_burst_len,
  input  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  input  logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
  output logic                      wr_burst_data_req,
  output logic                      rd_burst_data_valid,
  output logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  output logic                      rd_burst_finish,
  output logic                      wr_burst_finish,
  output logic                      busy
);

  localparam logic [DDR_ADDR_WIDTH-1:0] STEP = DDR_ADDR_WIDTH'(ADDR_STEP);

  burst_state_t                      state_reg, state_next;
  logic [BURST_LEN_WIDTH-1:0]        len_reg, len_next;
  logic [BURST_LEN_WIDTH-1:0]        cnt_reg, cnt_next;
  logic [MEM_ADDR_WIDTH-1:0]         word_reg, word_next;
  logic                              is_rd_reg, is_rd_next;
  logic                              valid_reg;
  logic [DDR_DATA_WIDTH-1:0]         hold_reg;
  logic                              ram_we, ram_re, last_beat;
  logic [DDR_DATA_WIDTH-1:0]         ram_rdata;

  assign last_beat = (cnt_reg == len_reg - 10'd1);

  always_comb begin
    state_next        = state_reg;
    len_next          = len_reg;
    cnt_next          = cnt_reg;
    word_next         = word_reg;
    is_rd_next        = is_rd_reg;
    ram_we            = 1'b0;
    ram_re            = 1'b0;
    wr_burst_data_req = 1'b0;
    rd_burst_finish   = 1'b0;
    wr_burst_finish   = 1'b0;
    busy              = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rd_burst_req) begin
          is_rd_next = 1'b1;
          len_next   = rd_burst_len;
          word_next  = MEM_ADDR_WIDTH'(rd_burst_addr / STEP);
          state_next = (rd_burst_len == '0) ? FINISH : READ;
        end else if (wr_burst_req) begin
          is_rd_next = 1'b0;
          len_next   = wr_burst_len;
          word_next  = MEM_ADDR_WIDTH'(wr_burst_addr / STEP);
          state_next = (wr_burst_len == '0) ? FINISH : WRITE;
        end
      end
      WRITE: begin
        wr_burst_data_req = 1'b1;
        ram_we            = 1'b1;
        word_next         = word_reg + 1'b1;
        cnt_next          = cnt_reg + 1'b1;
        if (last_beat) state_next = FINISH;
      end
      READ: begin
        ram_re    = 1'b1;
        word_next = word_reg + 1'b1;
        cnt_next  = cnt_reg + 1'b1;
        if (last_beat) state_next = READ_DRAIN;
      end
      READ_DRAIN: state_next = FINISH;
      FINISH: begin
        rd_burst_finish = is_rd_reg;
        wr_burst_finish = !is_rd_reg;
        state_next      = RELEASE;
      end
      RELEASE: begin
        if (is_rd_reg ? !rd_burst_req : !wr_burst_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      word_reg  <= '0;
      is_rd_reg <= 1'b0;
      valid_reg <= 1'b0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
      is_rd_reg <= is_rd_next;
      // Read data returns one cycle after each issue.
      valid_reg <= (state_reg == READ);
      if (valid_reg) hold_reg <= ram_rdata;
    end
  end

  // The RAM output register has no reset, so the last beat is shadowed in hold_reg.
  assign rd_burst_data_valid = valid_reg;
  assign rd_burst_data       = valid_reg ? ram_rdata : hold_reg;

  ddr_burst_ram #(
    .DATA_WIDTH (DDR_DATA_WIDTH),
    .ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_ram (
    .mem_clk (mem_clk),
    .wr_en   (ram_we),
    .wr_addr (word_reg),
    .wr_data (wr_burst_data),
    .rd_en   (ram_re),
    .rd_addr (word_reg),
    .rd_data (ram_rdata)
  );

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Table-driven bench with a read-data scoreboard for ddr_burst_responder.
module tb_ddr_burst_responder;

  logic         mem_clk = 1'b0;
  logic         rst;
  logic         rd_burst_req, wr_burst_req;
  logic [9:0]   rd_burst_len, wr_burst_len;
  logic [27:0]  rd_burst_addr, wr_burst_addr;
  logic [127:0] wr_burst_data;
  logic         wr_burst_data_req, rd_burst_data_valid, rd_burst_finish, wr_burst_finish, busy;
  logic [127:0] rd_burst_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] model [bit [15:0]];
  logic [127:0] sb_q [$];

  typedef struct {
    string        name;
    bit           is_rd;
    logic [27:0]  addr;
    int           len;
    logic [127:0] base;
    logic [127:0] exp_first;
  } vec_t;

  vec_t vecs [11];

  ddr_burst_responder dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_data_req   (wr_burst_data_req),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_finish     (rd_burst_finish),
    .wr_burst_finish     (wr_burst_finish),
    .busy                (busy)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input string name);
    if (sb_q.size() == 0) check({name, "_unexpected_beat"}, 1, 0);
    else check({name, "_data"}, rd_burst_data, sb_q.pop_front());
  endtask

  // Caller is at #1 after a rising edge; returns at the same phase.
  task automatic do_burst(input string name, input bit is_rd, input logic [27:0] addr,
                          input int len, input logic [127:0] base, input logic [127:0] exp_first);
    int beats, stray, first_cyc, last_cyc, fin_cyc, exp_fin, wait_cyc;
    logic [127:0] first_data, last_data;
    logic [15:0] w;
    w = 16'(addr / 8);
    beats = 0; stray = 0; first_cyc = -1; last_cyc = -1; fin_cyc = -1;
    first_data = '0; last_data = '0;
    if (is_rd) begin
      for (int i = 0; i < len; i++) sb_q.push_back(model[16'(w + i)]);
      rd_burst_addr = addr; rd_burst_len = 10'(len); rd_burst_req = 1'b1;
    end else begin
      wr_burst_addr = addr; wr_burst_len = 10'(len); wr_burst_req = 1'b1;
    end
    for (int cyc = 1; cyc <= len + 10 && fin_cyc < 0; cyc++) begin
      @(posedge mem_clk); #1;
      if (wr_burst_data_req) begin
        if (is_rd) stray++;
        else begin
          wr_burst_data = base + 128'(beats);
          model[16'(w + beats)] = wr_burst_data;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc; beats++;
        end
      end
      if (rd_burst_data_valid) begin
        if (!is_rd) stray++;
        else begin
          if (first_cyc < 0) begin first_cyc = cyc; first_data = rd_burst_data; end
          last_data = rd_burst_data;
          sb_compare(name);
          last_cyc = cyc; beats++;
        end
      end
      if (is_rd ? wr_burst_finish : rd_burst_finish) stray++;
      if (is_rd ? rd_burst_finish : wr_burst_finish) fin_cyc = cyc;
    end
    exp_fin = (len == 0) ? 1 : (is_rd ? len + 2 : len + 1);
    check({name, "_finish_cycle"}, fin_cyc, exp_fin);
    check({name, "_beats"}, beats, len);
    check({name, "_stray_strobes"}, stray, 0);
    if (len > 0) begin
      check({name, "_first_beat_cycle"}, first_cyc, is_rd ? 2 : 1);
      check({name, "_consecutive"}, last_cyc - first_cyc + 1, len);
      if (is_rd) check({name, "_first_data"}, first_data, exp_first);
    end
    @(posedge mem_clk); #1;
    check({name, "_finish_one_cycle"}, {rd_burst_finish, wr_burst_finish}, 2'b00);
    check({name, "_busy_in_release"}, busy, 1);
    if (is_rd && len > 0) check({name, "_data_hold"}, rd_burst_data, last_data);
    if (is_rd) rd_burst_req = 1'b0; else wr_burst_req = 1'b0;
    wait_cyc = 0;
    while (busy && wait_cyc < 5) begin @(posedge mem_clk); #1; wait_cyc++; end
    check({name, "_idle_after_release"}, busy, 0);
    check({name, "_scoreboard_empty"}, sb_q.size(), 0);
    $display("txn %s rd=%0d addr=%0h len=%0d beats=%0d finish_cycle=%0d", name, is_rd, addr, len, beats, fin_cyc);
  endtask

  initial begin
    int beats, wr_beats, fin, stray, wait_cyc;
    vecs[0]  = '{"wr4_addr0",   1'b0, 28'h0000000, 4, 128'h1,       128'h0};
    vecs[1]  = '{"rd4_addr0",   1'b1, 28'h0000000, 4, 128'h0,       128'h1};
    vecs[2]  = '{"wr1_hi",      1'b0, 28'h0070000, 1, 128'h60000,   128'h0};
    vecs[3]  = '{"rd1_hi",      1'b1, 28'h0070000, 1, 128'h0,       128'h60000};
    vecs[4]  = '{"rd1_noalias", 1'b1, 28'h0000000, 1, 128'h0,       128'h1};
    vecs[5]  = '{"rd_len0",     1'b1, 28'h0000000, 0, 128'h0,       128'h0};
    vecs[6]  = '{"wr3_wrap",    1'b0, 28'h007FFF8, 3, 128'hA0,      128'h0};
    vecs[7]  = '{"rd3_wrap",    1'b1, 28'h007FFF8, 3, 128'h0,       128'hA0};
    vecs[8]  = '{"rd2_word0",   1'b1, 28'h0000000, 2, 128'h0,       128'hA1};
    vecs[9]  = '{"wr_len0",     1'b0, 28'h0000100, 0, 128'h0,       128'h0};
    vecs[10] = '{"wr8_rstarea", 1'b0, 28'h0001000, 8, 128'h500,     128'h0};

    rst = 1'b0;
    rd_burst_req = 1'b0; wr_burst_req = 1'b0;
    rd_burst_len = '0; wr_burst_len = '0;
    rd_burst_addr = '0; wr_burst_addr = '0; wr_burst_data = '0;
    repeat (3) @(posedge mem_clk);
    #1;
    check("reset_strobes", {busy, rd_burst_data_valid, rd_burst_finish, wr_burst_finish, wr_burst_data_req}, 5'b0);
    check("reset_rd_data", rd_burst_data, 128'h0);
    @(negedge mem_clk) rst = 1'b1;
    @(posedge mem_clk); #1;

    foreach (vecs[i])
      do_burst(vecs[i].name, vecs[i].is_rd, vecs[i].addr, vecs[i].len, vecs[i].base, vecs[i].exp_first);

    // Simultaneous requests: read goes first, write waits for the read to be released.
    rd_burst_addr = 28'h0070000; rd_burst_len = 10'd1;
    wr_burst_addr = 28'h0000200; wr_burst_len = 10'd2;
    sb_q.push_back(model[16'hE000]);
    rd_burst_req = 1'b1; wr_burst_req = 1'b1;
    fin = 0; stray = 0; beats = 0;
    for (int c = 0; c < 10 && fin == 0; c++) begin
      @(posedge mem_clk); #1;
      if (wr_burst_data_req || wr_burst_finish) stray++;
      if (rd_burst_data_valid) begin sb_compare("both_rd"); beats++; end
      if (rd_burst_finish) fin = 1;
    end
    check("both_rd_finished", fin, 1);
    check("both_rd_beats", beats, 1);
    check("both_no_write_during_read", stray, 0);
    rd_burst_req = 1'b0;
    fin = 0; wr_beats = 0;
    for (int c = 0; c < 12 && fin == 0; c++) begin
      @(posedge mem_clk); #1;
      if (wr_burst_data_req) begin
        wr_burst_data = 128'h77 + 128'(wr_beats);
        model[16'(16'h40 + wr_beats)] = wr_burst_data;
        wr_beats++;
      end
      if (wr_burst_finish) fin = 1;
    end
    check("both_wr_finished", fin, 1);
    check("both_wr_beats", wr_beats, 2);
    wr_burst_req = 1'b0;
    wait_cyc = 0;
    while (busy && wait_cyc < 5) begin @(posedge mem_clk); #1; wait_cyc++; end
    check("both_idle", busy, 0);
    $display("txn both_requests rd_beats=%0d wr_beats=%0d", beats, wr_beats);
    do_burst("rd2_after_both", 1'b1, 28'h0000200, 2, 128'h0, 128'h77);

    // Reset during the third beat of a len=8 read.
    for (int i = 0; i < 8; i++) sb_q.push_back(model[16'(16'h200 + i)]);
    rd_burst_addr = 28'h0001000; rd_burst_len = 10'd8; rd_burst_req = 1'b1;
    beats = 0;
    for (int c = 0; c < 12 && beats < 3; c++) begin
      @(posedge mem_clk); #1;
      if (rd_burst_data_valid) begin sb_compare("rst_rd"); beats++; end
    end
    check("rst_reached_beat3", beats, 3);
    rst = 1'b0; #1;
    check("rst_abort_strobes", {busy, rd_burst_data_valid, rd_burst_finish, wr_burst_finish, wr_burst_data_req}, 5'b0);
    check("rst_abort_rd_data", rd_burst_data, 128'h0);
    sb_q.delete();
    rd_burst_req = 1'b0;
    stray = 0;
    @(negedge mem_clk) rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge mem_clk); #1;
      if (rd_burst_finish || wr_burst_finish || busy) stray++;
    end
    check("rst_no_finish_after", stray, 0);
    $display("txn reset_mid_read beats_before_reset=%0d", beats);
    do_burst("rd2_after_rst", 1'b1, 28'h0001000, 2, 128'h0, 128'h500);

    // Maximum length burst.
    do_burst("wr1023", 1'b0, 28'h0040000, 1023, 128'h1000_0000, 128'h0);
    do_burst("rd1023", 1'b1, 28'h0040000, 1023, 128'h0, 128'h1000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
